// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and types for the register file.
//   RF_WIDTH / RF_DEPTH  default entry width and entry count
//   RF_AW                address width derived from RF_DEPTH
//   rf_addr_t / rf_data_t  address and data types at the default sizes
//   RF_ZERO_ADDR         address of the hardwired-zero entry
package rf_pkg;

    localparam int RF_WIDTH     = 4;
    localparam int RF_DEPTH     = 8;
    localparam int RF_AW        = $clog2(RF_DEPTH);
    localparam int RF_ZERO_ADDR = 0;

    typedef logic [RF_AW-1:0]    rf_addr_t;
    typedef logic [RF_WIDTH-1:0] rf_data_t;

endpackage : rf_pkg

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read port of the register file.
//   CLK, RST     clock and synchronous active-high reset
//   re, raddr    read request and address
//   mem_data     current contents of the addressed entry (from the array)
//   wr_commit    a write lands at this edge (already excludes discarded writes)
//   waddr, wdata write address/data, used for the write-first bypass
//   q, valid     registered read data and its one-cycle strobe
//
// Handshake: there is no back-pressure. A request (re=1) seen at a non-reset
// edge always produces valid=1 for exactly the following cycle with q holding
// the read data; q keeps its value until the next request or reset.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int AW       = RF_AW,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             wr_commit,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0] rd_data;

    // The zero register wins over everything, then a same-edge write to the
    // same address returns the new data instead of the stale array contents.
    always_comb begin
        rd_data = mem_data;
        if (ZERO_REG && (raddr == AW'(RF_ZERO_ADDR))) begin
            rd_data = '0;
        end else if (wr_commit && (waddr == raddr)) begin
            rd_data = wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= re;
            if (re) begin
                q <= rd_data;
            end
        end
    end

endmodule : rf_read_port

// File: rtl/reg_file.sv
// reg_file: flat-register register file, one write port, two read ports.
//   CLK, RST                 clock and synchronous active-high reset
//   WE, WADDR, WDATA         write port
//   RE_A, RADDR_A, QA, VALID_A   read port A (one-cycle latency)
//   RE_B, RADDR_B, QB, VALID_B   read port B (one-cycle latency)
// AW is derived from DEPTH and must not be overridden.
module reg_file
    import rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             RE_A,
    input  logic [AW-1:0]    RADDR_A,
    output logic [WIDTH-1:0] QA,
    output logic             VALID_A,
    input  logic             RE_B,
    input  logic [AW-1:0]    RADDR_B,
    output logic [WIDTH-1:0] QB,
    output logic             VALID_B
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_commit;

    // Writes to the hardwired-zero entry are dropped here so neither the
    // array nor the bypass path ever sees them.
    assign wr_commit = WE && !(ZERO_REG && (WADDR == AW'(RF_ZERO_ADDR)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_commit) begin
            mem[WADDR] <= WDATA;
        end
    end

    rf_read_port #(
        .WIDTH    (WIDTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_port_a (
        .CLK       (CLK),
        .RST       (RST),
        .re        (RE_A),
        .raddr     (RADDR_A),
        .mem_data  (mem[RADDR_A]),
        .wr_commit (wr_commit),
        .waddr     (WADDR),
        .wdata     (WDATA),
        .q         (QA),
        .valid     (VALID_A)
    );

    rf_read_port #(
        .WIDTH    (WIDTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_port_b (
        .CLK       (CLK),
        .RST       (RST),
        .re        (RE_B),
        .raddr     (RADDR_B),
        .mem_data  (mem[RADDR_B]),
        .wr_commit (wr_commit),
        .waddr     (WADDR),
        .wdata     (WDATA),
        .q         (QB),
        .valid     (VALID_B)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
module tb_reg_file;
    import rf_pkg::*;

    localparam int OUT_W = 2 * RF_WIDTH + 2;

    // ---------------- clock / reset ----------------
    logic     CLK = 1'b0;
    logic     RST = 1'b0;
    logic     WE = 1'b0;
    rf_addr_t WADDR = '0;
    rf_data_t WDATA = '0;
    logic     RE_A = 1'b0;
    rf_addr_t RADDR_A = '0;
    rf_data_t QA;
    logic     VALID_A;
    logic     RE_B = 1'b0;
    rf_addr_t RADDR_B = '0;
    rf_data_t QB;
    logic     VALID_B;

    always #5 CLK = ~CLK;

    reg_file dut (
        .CLK     (CLK),
        .RST     (RST),
        .WE      (WE),
        .WADDR   (WADDR),
        .WDATA   (WDATA),
        .RE_A    (RE_A),
        .RADDR_A (RADDR_A),
        .QA      (QA),
        .VALID_A (VALID_A),
        .RE_B    (RE_B),
        .RADDR_B (RADDR_B),
        .QB      (QB),
        .VALID_B (VALID_B)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [OUT_W-1:0] exp_q[$];

    // reference model: plain array plus output registers
    rf_data_t m_mem [RF_DEPTH];
    rf_data_t m_qa, m_qb;
    logic     m_va, m_vb;

    typedef struct {
        logic     rst;
        logic     we;
        rf_addr_t waddr;
        rf_data_t wdata;
        logic     re_a;
        rf_addr_t raddr_a;
        logic     re_b;
        rf_addr_t raddr_b;
        rf_data_t exp_qa;
        logic     exp_va;
        rf_data_t exp_qb;
        logic     exp_vb;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic rst, input logic we, input int wa, input int wd,
                                input logic re_a, input int ra, input logic re_b, input int rb,
                                input int qa, input logic va, input int qb, input logic vb);
        vec_t v;
        v.rst = rst; v.we = we; v.waddr = rf_addr_t'(wa); v.wdata = rf_data_t'(wd);
        v.re_a = re_a; v.raddr_a = rf_addr_t'(ra); v.re_b = re_b; v.raddr_b = rf_addr_t'(rb);
        v.exp_qa = rf_data_t'(qa); v.exp_va = va; v.exp_qb = rf_data_t'(qb); v.exp_vb = vb;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic we, input rf_addr_t wa, input rf_data_t wd,
                         input logic re_a, input rf_addr_t ra, input logic re_b, input rf_addr_t rb);
        @(negedge CLK);
        RST = rst; WE = we; WADDR = wa; WDATA = wd;
        RE_A = re_a; RADDR_A = ra; RE_B = re_b; RADDR_B = rb;
    endtask

    task automatic settle();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [OUT_W-1:0] act,
                         input logic [OUT_W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got va=%0b qa=%h vb=%0b qb=%h, want va=%0b qa=%h vb=%0b qb=%h",
                     name, idx, act[OUT_W-1], act[OUT_W-2 -: RF_WIDTH], act[RF_WIDTH], act[RF_WIDTH-1:0],
                     exp[OUT_W-1], exp[OUT_W-2 -: RF_WIDTH], exp[RF_WIDTH], exp[RF_WIDTH-1:0]);
        end
    endtask

    function automatic logic [OUT_W-1:0] outs();
        return {VALID_A, QA, VALID_B, QB};
    endfunction

    // Model one clock edge: writes land first (write-first), entry 0 is never
    // written so reads of it naturally give zero.
    task automatic model_edge(input logic rst, input logic we, input rf_addr_t wa, input rf_data_t wd,
                              input logic re_a, input rf_addr_t ra, input logic re_b, input rf_addr_t rb);
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) m_mem[i] = '0;
            m_qa = '0; m_qb = '0; m_va = 1'b0; m_vb = 1'b0;
        end else begin
            if (we && wa != rf_addr_t'(RF_ZERO_ADDR)) m_mem[wa] = wd;
            m_va = re_a;
            m_vb = re_b;
            if (re_a) m_qa = m_mem[ra];
            if (re_b) m_qb = m_mem[rb];
        end
    endtask

    // ---------------- test ----------------
    initial begin
        // directed table: inputs for one edge, outputs expected after it
        vecs[0]  = mk(1, 0, 0, 0,    0, 0, 0, 0,   0,    0, 0,   0);
        vecs[1]  = mk(1, 0, 0, 0,    0, 0, 0, 0,   0,    0, 0,   0);
        vecs[2]  = mk(0, 0, 0, 0,    1, 3, 1, 3,   0,    1, 0,   1);
        vecs[3]  = mk(0, 0, 0, 0,    0, 0, 0, 0,   0,    0, 0,   0);
        vecs[4]  = mk(0, 1, 5, 'hA,  0, 0, 0, 0,   0,    0, 0,   0);
        vecs[5]  = mk(0, 0, 0, 0,    1, 5, 0, 0,   'hA,  1, 0,   0);
        vecs[6]  = mk(0, 0, 0, 0,    0, 0, 0, 0,   'hA,  0, 0,   0);
        vecs[7]  = mk(0, 1, 2, 3,    0, 0, 0, 0,   'hA,  0, 0,   0);
        vecs[8]  = mk(0, 1, 2, 7,    0, 0, 1, 2,   'hA,  0, 7,   1);
        vecs[9]  = mk(0, 0, 0, 0,    0, 0, 1, 2,   'hA,  0, 7,   1);
        vecs[10] = mk(0, 1, 0, 'hF,  1, 0, 0, 0,   0,    1, 7,   0);
        vecs[11] = mk(0, 0, 0, 0,    1, 0, 0, 0,   0,    1, 7,   0);
        vecs[12] = mk(0, 1, 4, 9,    0, 0, 0, 0,   0,    0, 7,   0);
        vecs[13] = mk(1, 0, 0, 0,    1, 4, 0, 0,   0,    0, 0,   0);
        vecs[14] = mk(0, 0, 0, 0,    1, 4, 0, 0,   0,    1, 0,   0);
        vecs[15] = mk(0, 1, 6, 5,    1, 6, 1, 6,   5,    1, 5,   1);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                  vecs[i].re_a, vecs[i].raddr_a, vecs[i].re_b, vecs[i].raddr_b);
            settle();
            check("table", i, outs(),
                  {vecs[i].exp_va, vecs[i].exp_qa, vecs[i].exp_vb, vecs[i].exp_qb});
        end

        // fill 1..7 then stream both ports in opposite directions
        for (int a = 1; a < RF_DEPTH; a++) begin
            drive(0, 1, rf_addr_t'(a), rf_data_t'(a), 0, '0, 0, '0);
        end
        for (int i = 0; i < RF_DEPTH - 1; i++) begin
            drive(0, 0, '0, '0, 1, rf_addr_t'(RF_DEPTH - 1 - i), 1, rf_addr_t'(i + 1));
            settle();
            check("stream", i, outs(),
                  {1'b1, rf_data_t'(RF_DEPTH - 1 - i), 1'b1, rf_data_t'(i + 1)});
        end
        drive(0, 0, '0, '0, 0, '0, 0, '0);
        settle();
        check("stream_end", 0, outs(), {1'b0, rf_data_t'(1), 1'b0, rf_data_t'(RF_DEPTH - 1)});

        // randomized run against the reference model, starting from reset
        model_edge(1, 0, '0, '0, 0, '0, 0, '0);
        drive(1, 0, '0, '0, 0, '0, 0, '0);
        settle();
        check("rand_reset", 0, outs(), {m_va, m_qa, m_vb, m_qb});
        for (int i = 0; i < 400; i++) begin
            logic     r_rst, r_we, r_rea, r_reb;
            rf_addr_t r_wa, r_ra, r_rb;
            rf_data_t r_wd;
            r_rst = ($urandom_range(0, 31) == 0);
            r_we  = ($urandom_range(0, 1) == 1);
            r_rea = ($urandom_range(0, 2) != 0);
            r_reb = ($urandom_range(0, 2) != 0);
            r_wa  = rf_addr_t'($urandom_range(0, RF_DEPTH - 1));
            r_wd  = rf_data_t'($urandom);
            // bias read addresses toward the write address to exercise bypass
            r_ra  = ($urandom_range(0, 3) == 0) ? r_wa : rf_addr_t'($urandom_range(0, RF_DEPTH - 1));
            r_rb  = ($urandom_range(0, 3) == 0) ? r_wa : rf_addr_t'($urandom_range(0, RF_DEPTH - 1));
            model_edge(r_rst, r_we, r_wa, r_wd, r_rea, r_ra, r_reb, r_rb);
            exp_q.push_back({m_va, m_qa, m_vb, m_qb});
            drive(r_rst, r_we, r_wa, r_wd, r_rea, r_ra, r_reb, r_rb);
            settle();
            check("random", i, outs(), exp_q.pop_front());
        end

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
Name: reg_file

Overview:
- Multi-entry register file for the basic RISC datapath. It is the read-side counterpart to the single enabled storage register.
- One enabled write port stores results.
- Two independent registered read ports return operands one cycle after a request, each with a valid strobe.
- Sits between writeback and the ALU operand inputs.

Parameters:
WIDTH, 4, data width of each entry
DEPTH, 8, number of entries (power of two, >= 2)
AW, $clog2(DEPTH), address width (derived, not overridden)
ZERO_REG, 1, when 1 entry 0 is hardwired to zero and ignores writes

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  reset, synchronous, active-high
WE  input  1  write enable
WADDR  input  AW  write address
WDATA  input  WIDTH  write data
RE_A  input  1  read request, port A
RADDR_A  input  AW  read address, port A
QA  output  WIDTH  read data, port A (registered)
VALID_A  output  1  QA updated this cycle, port A
RE_B  input  1  read request, port B
RADDR_B  input  AW  read address, port B
QB  output  WIDTH  read data, port B (registered)
VALID_B  output  1  QB updated this cycle, port B

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high (CLK, RST).
  - RST has priority over all requests.
  - At the reset edge: every entry <= 0, QA = QB = 0, VALID_A = VALID_B = 0.
- Write:
  - At an edge with WE=1 and !RST: MEM[WADDR] <= WDATA.
  - If ZERO_REG=1 and WADDR=0, the write is discarded.
  - WE=0 leaves all entries unchanged.
- Read, per port X in {A, B}:
  - At an edge with RE_X=1: QX <= contents of RADDR_X and VALID_X <= 1. Latency is one cycle.
  - At an edge with RE_X=0: VALID_X <= 0 and QX holds its last value. QX never returns to 0 except on reset.
  - VALID_X is a one-cycle strobe per request. Back-to-back requests give VALID_X high on consecutive cycles.
- Read-during-write bypass:
  - Applies when, at the same edge, WE=1, RE_X=1, RADDR_X=WADDR, and the write is not discarded.
  - In that case QX <= WDATA (new data, write-first).
- Zero register: with ZERO_REG=1, a read of address 0 returns 0 regardless of any write or bypass to address 0.
- Simultaneous events:
  - A and B may read the same address in the same cycle; both return identical data.
  - Both ports may bypass in the same cycle.
- Reset mid-operation: a request presented in the same cycle as RST=1 is dropped. No VALID follows it.
- Out-of-range addresses cannot occur, since DEPTH is a power of two.
- Storage is a flat register array; no memory macro is inferred.

Decomposition:
- Shared package rf_pkg holds:
  - default WIDTH/DEPTH constants
  - typedef rf_addr_t (logic [AW-1:0])
  - typedef rf_data_t (logic [WIDTH-1:0])
  - constant RF_ZERO_ADDR = 0
- Sub-module rf_read_port, instantiated twice (A, B). It contains:
  - bypass compare
  - zero-register mux
  - QX/VALID_X registers
- The top level owns the storage array and the write logic.

Test Plan:
1. RST=1 for 2 cycles, then RE_A=RE_B=1 at addr 3 -> next cycle QA=QB=0 and VALID_A=VALID_B=1; during reset VALID_A=VALID_B=0.
2. WE=1, WADDR=5, WDATA=4'hA; next cycle RE_A=1, RADDR_A=5 -> one cycle later QA=4'hA, VALID_A=1; the following cycle with RE_A=0, VALID_A=0 and QA stays 4'hA.
3. Same-cycle WE=1, WADDR=2, WDATA=4'h7 with RE_B=1, RADDR_B=2 (old content 4'h3) -> next cycle QB=4'h7 (bypass); a later read of 2 also returns 4'h7.
4. ZERO_REG=1: WE=1, WADDR=0, WDATA=4'hF with RE_A=1, RADDR_A=0 in the same cycle, then read 0 again -> QA=0 both times.
5. Fill entries 1..7 with values 1..7, then stream RE_A over addresses 7..1 and RE_B over 1..7 on consecutive cycles -> each port returns the matching value one cycle later, with VALID continuously high for 7 cycles.
6. Write 4'h9 to addr 4, then assert RE_A=1, RADDR_A=4 together with RST=1 -> next cycle VALID_A=0, QA=0; a read of addr 4 returns 0.
